// File: rtl/spi_master.sv
// spi_master: SPI master, any CPOL/CPHA mode, MSB first, registered pins.
// Build option SPI_MASTER_LOOPBACK_EN: receive path samples MOSI, not MISO.
module spi_master #(
  parameter logic [1:0] mode      = 2'b00,
  parameter int         bits_size = 8,
  parameter int         clk_div   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [bits_size-1:0] data_in,
  input  logic                 start,
  output logic [bits_size-1:0] data_out,
  output logic                 tx_done,
  output logic                 rx_done,
  output logic                 busy,
  output logic                 ss,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam logic CPOL = mode[1];
  localparam logic CPHA = mode[0];
  localparam int   CW   = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int   EW   = $clog2(2 * bits_size + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(clk_div - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * bits_size - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        cnt;
  logic [EW-1:0]        edge_cnt;
  logic [bits_size-1:0] tx_sr;
  logic [bits_size-1:0] rx_sr;
  logic                 tick;
  logic                 accept;
  logic                 sclk_edge;
  logic                 leading;
  logic                 last_edge;
  logic                 rx_bit;

  assign tick      = (cnt == CNT_LAST);
  assign accept    = (state == IDLE) && start;
  assign sclk_edge = tick && ((state == SETUP) || (state == SHIFT));
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EDGE_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = MOSI;
`else
  assign rx_bit = MISO;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode: phases end on half-period ticks
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   if (tick) state_nx = SHIFT;
      SHIFT:   if (tick && last_edge) state_nx = HOLD;
      HOLD:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters, shift registers and registered pins
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      data_out <= '0;
      tx_done  <= 1'b0;
      rx_done  <= 1'b0;
      busy     <= 1'b0;
      ss       <= 1'b1;
      SCLK     <= CPOL;
      MOSI     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      rx_done <= 1'b0;
      if (accept) begin
        cnt      <= '0;
        edge_cnt <= '0;
        tx_sr    <= data_in;
        rx_sr    <= '0;
        MOSI     <= data_in[bits_size-1];
        ss       <= 1'b0;
        busy     <= 1'b1;
      end else if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + CW'(1);
        if (sclk_edge) begin
          SCLK     <= ~SCLK;
          edge_cnt <= edge_cnt + EW'(1);
          if (leading ^ CPHA)
            rx_sr <= {rx_sr[bits_size-2:0], rx_bit};
          if (CPHA && leading) begin
            MOSI  <= tx_sr[bits_size-1];
            tx_sr <= {tx_sr[bits_size-2:0], 1'b0};
          end
          if (!CPHA && !leading && !last_edge) begin
            MOSI  <= tx_sr[bits_size-2];
            tx_sr <= {tx_sr[bits_size-2:0], 1'b0};
          end
        end
        if ((state == HOLD) && tick) begin
          ss       <= 1'b1;
          busy     <= 1'b0;
          SCLK     <= CPOL;
          data_out <= rx_sr;
          tx_done  <= 1'b1;
          rx_done  <= 1'b1;
        end
      end
    end
  end

endmodule
